// File: rtl/pov_texture_mapper.sv
// Maps (theta, LED index) to a texture-ROM address and returns the fetched GRB pixel.
// Latency ROM_LATENCY+2 cycles from px_req to pixel_valid, one pixel per clock, no backpressure.
module pov_texture_mapper #(
   parameter int LED_COUNT    = 52,
   parameter int TEX_WIDTH    = 128,
   parameter int NUM_TEXTURES = 5,
   parameter int THETA_BITS   = 6,
   parameter int PX_BITS      = 6,
   parameter int TEX_IDX_BITS = 4,
   parameter int ROM_LATENCY  = 1,
   parameter int ADDR_BITS    = $clog2(TEX_WIDTH*NUM_TEXTURES*LED_COUNT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [THETA_BITS-1:0]   theta,
   input  logic                    rev_start,
   input  logic                    px_req,
   input  logic [PX_BITS-1:0]      px_num,
   input  logic [THETA_BITS-1:0]   phase_offset,
   input  logic                    mirror_en,
   input  logic                    tex_wr,
   input  logic [TEX_IDX_BITS-1:0] tex_wdata,
   output logic [ADDR_BITS-1:0]    rom_addr,
   input  logic [23:0]             rom_data,
   output logic [23:0]             pixel_out,
   output logic                    pixel_valid,
   output logic [TEX_IDX_BITS-1:0] active_tex,
   output logic                    tex_err,
   output logic [15:0]             rev_count
);

   localparam int COL_BITS = $clog2(TEX_WIDTH);

   localparam logic [PX_BITS-1:0]      LED_LIMIT  = PX_BITS'(LED_COUNT);
   localparam logic [PX_BITS-1:0]      LED_HALF   = PX_BITS'(LED_COUNT / 2);
   localparam logic [PX_BITS-1:0]      LED_LAST   = PX_BITS'(LED_COUNT - 1);
   localparam logic [THETA_BITS-1:0]   HALF_TURN  = {1'b1, {(THETA_BITS-1){1'b0}}};
   localparam logic [ADDR_BITS-1:0]    ROW_STRIDE = ADDR_BITS'(TEX_WIDTH * NUM_TEXTURES);
   localparam logic [ADDR_BITS-1:0]    TEX_STRIDE = ADDR_BITS'(TEX_WIDTH);
   localparam logic [TEX_IDX_BITS-1:0] TEX_LIMIT  = TEX_IDX_BITS'(NUM_TEXTURES);

   logic [TEX_IDX_BITS-1:0] pending_tex;
   logic [THETA_BITS-1:0]   th_sum;
   logic [THETA_BITS-1:0]   th_eff;
   logic [PX_BITS-1:0]      row;
   logic [COL_BITS-1:0]     col;
   logic                    in_range;
   logic                    mirrored;
   logic                    wr_ok;
   logic [ADDR_BITS-1:0]    addr_next;
   logic [ROM_LATENCY:0]    vld_pipe;
   logic [ROM_LATENCY:0]    blank_pipe;

   always_comb begin
      th_sum    = theta + phase_offset;
      in_range  = px_num < LED_LIMIT;
      mirrored  = mirror_en && (px_num >= LED_HALF);
      // Far half of a two-sided strip shows the opposite side of the image
      th_eff    = mirrored ? (th_sum ^ HALF_TURN) : th_sum;
      row       = mirrored ? (LED_LAST - px_num) : px_num;
      col       = COL_BITS'({th_eff, {COL_BITS{1'b0}}} >> THETA_BITS);
      addr_next = ADDR_BITS'(row) * ROW_STRIDE
                + ADDR_BITS'(active_tex) * TEX_STRIDE
                + ADDR_BITS'(col);
      wr_ok     = tex_wr && (tex_wdata < TEX_LIMIT);
   end

   // A valid write coinciding with rev_start goes straight to the active texture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_tex <= '0;
         active_tex  <= '0;
         tex_err     <= 1'b0;
         rev_count   <= 16'd0;
      end else begin
         tex_err <= tex_wr && !wr_ok;
         if (wr_ok)
            pending_tex <= tex_wdata;
         if (rev_start) begin
            active_tex <= wr_ok ? tex_wdata : pending_tex;
            rev_count  <= rev_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rom_addr <= '0;
      else if (px_req && in_range)
         rom_addr <= addr_next;
   end

   // Tags travel alongside the ROM access so blank requests still produce a pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe    <= '0;
         blank_pipe  <= '0;
         pixel_valid <= 1'b0;
         pixel_out   <= 24'h0;
      end else begin
         vld_pipe    <= {vld_pipe[ROM_LATENCY-1:0], px_req};
         blank_pipe  <= {blank_pipe[ROM_LATENCY-1:0], px_req && !in_range};
         pixel_valid <= vld_pipe[ROM_LATENCY];
         if (vld_pipe[ROM_LATENCY])
            pixel_out <= blank_pipe[ROM_LATENCY] ? 24'h0 : rom_data;
      end
   end

endmodule

// File: tb/tb_pov_texture_mapper.sv
// Directed and random stimulus for pov_texture_mapper against a plain-arithmetic reference model.
module tb_pov_texture_mapper;

   logic        clk;
   logic        reset;
   logic [5:0]  theta;
   logic        rev_start;
   logic        px_req;
   logic [5:0]  px_num;
   logic [5:0]  phase_offset;
   logic        mirror_en;
   logic        tex_wr;
   logic [3:0]  tex_wdata;
   logic [15:0] rom_addr;
   logic [23:0] rom_data;
   logic [23:0] pixel_out;
   logic        pixel_valid;
   logic [3:0]  active_tex;
   logic        tex_err;
   logic [15:0] rev_count;

   pov_texture_mapper dut (
      .clk(clk), .reset(reset), .theta(theta), .rev_start(rev_start),
      .px_req(px_req), .px_num(px_num), .phase_offset(phase_offset),
      .mirror_en(mirror_en), .tex_wr(tex_wr), .tex_wdata(tex_wdata),
      .rom_addr(rom_addr), .rom_data(rom_data), .pixel_out(pixel_out),
      .pixel_valid(pixel_valid), .active_tex(active_tex), .tex_err(tex_err),
      .rev_count(rev_count)
   );

   typedef struct {
      int          due;
      logic [23:0] dat;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          m_pending, m_active, m_rev, m_addr;
   logic [23:0] last_pix = 24'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] rom_fn(input logic [15:0] a);
      return {a[7:0] ^ 8'hC3, a};
   endfunction

   // One-cycle ROM
   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   function automatic int exp_addr(input int th_in, input int ph, input int px, input bit mir, input int act);
      int th, row, col;
      th  = (th_in + ph) % 64;
      row = px;
      if (mir && px >= 26) begin
         th  = (th + 32) % 64;
         row = 51 - px;
      end
      col = (th * 128) / 64;
      return row * 640 + act * 128 + col;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0 && q[0].due <= cyc) begin
         check("pixel_valid", 32'(pixel_valid), 32'd1);
         check("pixel_out", 32'(pixel_out), 32'(q[0].dat));
         last_pix = q[0].dat;
         void'(q.pop_front());
      end else begin
         check("pixel_idle", 32'(pixel_valid), 32'd0);
         check("pixel_hold", 32'(pixel_out), 32'(last_pix));
      end
   end

   task automatic step(input bit req, input int px, input int th, input int ph, input bit mir,
                       input bit wr, input int wd, input bit rs);
      int a;
      bit blank, werr;
      px_req = req; px_num = 6'(px); theta = 6'(th); phase_offset = 6'(ph);
      mirror_en = mir; tex_wr = wr; tex_wdata = 4'(wd); rev_start = rs;
      blank = (px >= 52);
      a = blank ? m_addr : exp_addr(th, ph, px, mir, m_active);
      @(posedge clk);
      #1;
      if (req) begin
         if (!blank) m_addr = a;
         q.push_back('{cyc + 2, blank ? 24'h0 : rom_fn(16'(a))});
      end
      werr = wr && (wd >= 5);
      if (wr && !werr) m_pending = wd;
      if (rs) begin
         m_active = m_pending;
         m_rev    = (m_rev + 1) % 65536;
      end
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("active_tex", 32'(active_tex), 32'(m_active));
      check("tex_err", 32'(tex_err), 32'(werr));
      check("rev_count", 32'(rev_count), 32'(m_rev));
      px_req = 1'b0; tex_wr = 1'b0; rev_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; theta = '0; rev_start = 1'b0; px_req = 1'b0; px_num = '0;
      phase_offset = '0; mirror_en = 1'b0; tex_wr = 1'b0; tex_wdata = '0;
      m_pending = 0; m_active = 0; m_rev = 0; m_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_rev_count", 32'(rev_count), 32'd0);
      check("rst_active", 32'(active_tex), 32'd0);
      check("rst_tex_err", 32'(tex_err), 32'd0);
      reset = 1'b0;

      // Origin pixel, then theta wrap with phase offset
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("addr_origin", 32'(rom_addr), 32'd0);
      idle(3);
      step(1, 1, 63, 2, 0, 0, 0, 0);
      check("addr_phase_wrap", 32'(rom_addr), 32'd642);
      idle(3);

      // Double-buffered texture select
      step(0, 0, 0, 0, 0, 1, 3, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("addr_pending_ignored", 32'(rom_addr), 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("active_after_rev", 32'(active_tex), 32'd3);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("addr_tex3", 32'(rom_addr), 32'd384);
      step(0, 0, 0, 0, 0, 1, 7, 0);
      check("tex_err_pulse", 32'(tex_err), 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("active_kept", 32'(active_tex), 32'd3);
      check("rev_two", 32'(rev_count), 32'd2);

      // Mirror mode on both halves
      step(1, 51, 0, 0, 1, 0, 0, 0);
      check("addr_mirror_far", 32'(rom_addr), 32'd448);
      step(1, 25, 0, 0, 1, 0, 0, 0);
      check("addr_mirror_near", 32'(rom_addr), 32'(25 * 640 + 384));
      idle(3);

      // Back-to-back full column, then an out-of-range LED
      for (int p = 0; p < 52; p++) step(1, p, 17, 5, 0, 0, 0, 0);
      step(1, 60, 9, 0, 0, 0, 0, 0);
      check("addr_blank_hold", 32'(rom_addr), 32'(51 * 640 + 384 + 44));
      idle(3);

      for (int i = 0; i < 300; i++) begin
         step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 7)), bit'($urandom_range(0, 19) == 0));
      end
      idle(4);

      // Reset with two requests in flight
      step(1, 3, 10, 0, 0, 0, 0, 0);
      step(1, 4, 11, 0, 0, 0, 0, 0);
      #1;
      reset = 1'b1;
      q.delete();
      last_pix = 24'h0;
      m_pending = 0; m_active = 0; m_rev = 0; m_addr = 0;
      #1;
      check("rst2_pixel_out", 32'(pixel_out), 32'd0);
      check("rst2_pixel_valid", 32'(pixel_valid), 32'd0);
      check("rst2_rom_addr", 32'(rom_addr), 32'd0);
      check("rst2_rev_count", 32'(rev_count), 32'd0);
      check("rst2_active", 32'(active_tex), 32'd0);
      idle(2);
      reset = 1'b0;
      idle(6);

      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
